cordic_phase_gen: RTL
=====================

# cordic_phase_gen

Angle sequencer that sits directly upstream of the pipelined CORDIC sine/cosine core. It produces a stream of signed Q16.16 angles in degrees, wrapped to the CORDIC input range, paced by a programmable sample interval. Each sample is flagged with a one-cycle valid strobe that drives the core's valid input. It supports finite bursts and continuous runs, with start/stop control and a done pulse for the host controller.

## Interface
Parameters:
- `CNT_W`, default 16: width of the sample-count and interval-divider registers.

Ports:
- `clk`, input, 1: single clock; all logic rising-edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: one-cycle request to begin a run; ignored unless IDLE.
- `stop`, input, 1: one-cycle abort request.
- `phase_init`, input, 32 (signed Q16.16 degrees): first angle of the run.
- `freq_word`, input, 32 (signed Q16.16 degrees): increment per sample.
- `sample_cnt`, input, CNT_W: number of samples in the run; 0 means continuous.
- `div`, input, CNT_W: interval between samples, in (div+1) clocks.
- `angle`, output, 32 (signed Q16.16): current angle, always in [-180°, +180°).
- `angle_vaild`, output, 1: one-cycle strobe marking a new `angle`.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse when a run ends (completion or stop).

## Operation
- Constants: D180 = 11796480 (180·2^16), D360 = 23592960.
- Wrap rule W(v), single step, on a 33-bit signed intermediate:
  - v ≥ D180 → v − D360
  - v < −D180 → v + D360
  - otherwise v
- On accepted `start`, the block latches the following:
  - phase ← W(phase_init)
  - step ← freq_word clamped to [−D180, +D180]. The clamp guarantees one wrap step is always enough.
  - remaining samples ← sample_cnt
  - interval ← div
- States:
  - **IDLE**
    - `start` & !`stop` → RUN.
    - `start` & `stop` in the same cycle → stay IDLE, no `done`.
  - **RUN**
    - Tick counter counts from div down to 0. On reaching 0 it emits a sample and reloads div.
    - A sample does: `angle` ← phase, `angle_vaild` = 1, then phase ← W(phase + step).
    - With sample_cnt ≠ 0, the remaining count decrements per sample. The sample that brings it to 0 is the last: the block returns to IDLE and pulses `done` in the same cycle as that final `angle_vaild`.
    - With sample_cnt = 0, RUN continues until `stop`.
    - `stop` in RUN → IDLE next cycle, `done` = 1 that cycle, no further `angle_vaild`.
    - If `stop` coincides with a sample tick, the sample is suppressed.
    - `start` in RUN is ignored.
- `angle` holds its last value between strobes and across IDLE.
- Input ports are don't-care except at `start` acceptance.

## Timing
- Reset values:
  - state IDLE
  - `angle` = 0
  - `angle_vaild` = 0
  - `busy` = 0
  - `done` = 0
  - all counters 0
- Reset mid-run aborts immediately, with no `done` pulse.
- All outputs are registered.
- `start` sampled at edge T → `busy` = 1 and first `angle_vaild` at T+1. The first sample always issues without waiting for the interval.
- Subsequent strobes occur every div+1 cycles. With div = 0, `angle_vaild` is high on consecutive cycles.
- Burst of N samples: last strobe at T+1+(N−1)(div+1); `busy` falls the following cycle.
- Wrap arithmetic is exact: no saturation of phase, no accumulated error beyond the step quantisation.
- Downstream core latency is not this block's concern. The block does not accept backpressure: the consumer must accept one sample per cycle.

## Structure
- Shared package `cordic_pkg` holds:
  - constants D180, D360
  - the state enum (IDLE, RUN)
  - the Q16.16 angle width constant, also used by the CORDIC core
- One natural sub-module: `cordic_angle_wrap`. It is combinational and implements the single-step W(v) with step clamping. It is instantiated for both the phase_init load and the accumulate path.
- The rest is one FSM, a tick counter, a sample counter and the phase register, in the top module.

## Test plan
- **Reset:** assert `rst` mid-run → next cycle all outputs 0 and state IDLE. A later `start` behaves normally.
- **Burst, no wrap:** phase_init = 0, freq_word = 10·2^16, sample_cnt = 4, div = 2.
  - `angle` sequence 0, 655360, 1310720, 1966080.
  - Strobes at T+1, T+4, T+7, T+10.
  - `done` at T+10; `busy` low at T+11.
- **Wrap:** phase_init = 170·2^16, freq_word = 20·2^16, sample_cnt = 3, div = 0.
  - Angles 11141120, −11141120 (−170°), −9830400 (−150°) on consecutive cycles.
- **Negative wrap and clamp:**
  - phase_init = −175·2^16, freq_word = −10·2^16 → second angle +175·2^16.
  - freq_word = 400·2^16 → step latched as D180.
- **Continuous + stop:** sample_cnt = 0, div = 1, run 20 cycles, then `stop` on a tick cycle.
  - That sample is suppressed; `done` pulses once; no strobes afterwards.
- **Control corner:** `start` & `stop` together in IDLE → nothing happens. `start` during RUN → sequence unaffected.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC angle front end: Q16.16 degree constants,
// sequencer states and the step clamp used by the wrap stage.
package cordic_pkg;

  localparam int ANGLE_W = 32;

  localparam logic signed [ANGLE_W:0] D180 = 33'sd11796480;
  localparam logic signed [ANGLE_W:0] D360 = 33'sd23592960;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Limit a per-sample step to [-180, +180] degrees so one wrap step suffices.
  function automatic logic signed [ANGLE_W-1:0] clamp_step(input logic signed [ANGLE_W-1:0] s);
    logic signed [ANGLE_W:0] w;
    w = {s[ANGLE_W-1], s};
    if (w > D180)
      clamp_step = ANGLE_W'(D180);
    else if (w < -D180)
      clamp_step = ANGLE_W'(-D180);
    else
      clamp_step = s;
  endfunction

endpackage

// File: rtl/cordic_angle_wrap.sv
// Combinational base + clamp(incr) with a single-step wrap into [-180, +180).
// The sum is formed on 33 bits so the wrap compare sees the true value.
module cordic_angle_wrap
  import cordic_pkg::*;
(
  input  logic signed [ANGLE_W-1:0] base,
  input  logic signed [ANGLE_W-1:0] incr,
  output logic signed [ANGLE_W-1:0] wrapped
);

  logic signed [ANGLE_W-1:0] step;
  logic signed [ANGLE_W:0]   sum;

  always_comb begin
    step = clamp_step(incr);
    sum  = {base[ANGLE_W-1], base} + {step[ANGLE_W-1], step};
    if (sum >= D180)
      wrapped = ANGLE_W'(sum - D360);
    else if (sum < -D180)
      wrapped = ANGLE_W'(sum + D360);
    else
      wrapped = ANGLE_W'(sum);
  end

endmodule

// File: rtl/cordic_phase_gen.sv
// Paced Q16.16 angle sequencer feeding the CORDIC core, with burst and
// continuous modes, stop abort and a done pulse.
//
// state | meaning
// IDLE  | waiting for start; angle holds last value
// RUN   | tick counter pacing samples; phase accumulating
module cordic_phase_gen
  import cordic_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic signed [ANGLE_W-1:0] phase_init,
  input  logic signed [ANGLE_W-1:0] freq_word,
  input  logic [CNT_W-1:0]          sample_cnt,
  input  logic [CNT_W-1:0]          div,
  output logic signed [ANGLE_W-1:0] angle,
  output logic                      angle_vaild,
  output logic                      busy,
  output logic                      done
);

  state_t                    state;
  logic signed [ANGLE_W-1:0] phase_q;
  logic signed [ANGLE_W-1:0] step_q;
  logic [CNT_W-1:0]          remain_q;
  logic [CNT_W-1:0]          div_q;
  logic [CNT_W-1:0]          tick_q;
  logic                      cont_q;

  logic signed [ANGLE_W-1:0] init_phase;
  logic signed [ANGLE_W-1:0] acc_base;
  logic signed [ANGLE_W-1:0] acc_incr;
  logic signed [ANGLE_W-1:0] next_phase;

  cordic_angle_wrap u_init_wrap (
    .base    (phase_init),
    .incr    ('0),
    .wrapped (init_phase)
  );

  // In IDLE the accumulator is chained off the init wrap, because the first
  // sample issues at start acceptance and the phase must already be advanced.
  always_comb begin
    acc_base = phase_q;
    acc_incr = step_q;
    if (state == IDLE) begin
      acc_base = init_phase;
      acc_incr = freq_word;
    end
  end

  cordic_angle_wrap u_acc_wrap (
    .base    (acc_base),
    .incr    (acc_incr),
    .wrapped (next_phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      phase_q     <= '0;
      step_q      <= '0;
      remain_q    <= '0;
      div_q       <= '0;
      tick_q      <= '0;
      cont_q      <= 1'b0;
      angle       <= '0;
      angle_vaild <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      angle_vaild <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start && !stop) begin
            state       <= RUN;
            busy        <= 1'b1;
            angle       <= init_phase;
            angle_vaild <= 1'b1;
            phase_q     <= next_phase;
            step_q      <= clamp_step(freq_word);
            div_q       <= div;
            tick_q      <= div;
            cont_q      <= (sample_cnt == '0);
            remain_q    <= sample_cnt - CNT_W'(1);
            if (sample_cnt == CNT_W'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tick_q == '0) begin
            angle       <= phase_q;
            angle_vaild <= 1'b1;
            phase_q     <= next_phase;
            tick_q      <= div_q;
            remain_q    <= remain_q - CNT_W'(1);
            // busy stays high through the final strobe and drops from IDLE
            if (!cont_q && remain_q == CNT_W'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else begin
            tick_q <= tick_q - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
